seq_detect_prog: RTL and testbench

- Parametrised, runtime-programmable successor to the fixed "001" Moore detector.
- Detects an arbitrary PAT_W-bit serial pattern on a single-bit input stream.
- Supports selectable overlapping or non-overlapping detection, an input-valid qualifier, and a saturating detection counter.
- Sits at the serial front end; det feeds downstream control logic and det_count feeds status readback.

---
 rtl/seq_detect_prog.sv | 108 ++++++++++
 tb/tb_seq_detect_prog.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector (Moore) with KMP-style fallback and saturating hit counter.
// Optional build macro SEQ_DETECT_MASK_EN adds a per-bit don't-care mask loaded alongside the pattern.
//
// state (l_q)        | meaning
// 0                  | no pattern prefix matched
// 1 .. PAT_W-1       | that many leading pattern bits matched
// PAT_W (MATCH)      | full pattern seen, det=1
module seq_detect_prog #(
  parameter int               PAT_W   = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b001)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inp,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pat,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_W-1:0] pat_mask,
`endif
  input  logic             pat_load,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             det,
  output logic [CNT_W-1:0] det_count,
  output logic             cnt_sat
);

  localparam int            LW      = $clog2(PAT_W + 1);
  localparam logic [LW-1:0] L_MATCH = LW'(PAT_W);

  logic [LW-1:0]    l_q, l_d;
  logic [PAT_W-1:0] pat_q, mask_q, win;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [CNT_W-1:0] cnt_d;
  logic             enter_match;
  logic             hit;
  int               limit;

`ifdef SEQ_DETECT_MASK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mask_q <= '1;
    else if (pat_load)
      mask_q <= pat_mask;
  end
`else
  assign mask_q = '1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_q       <= '0;
      hist_q    <= '0;
      pat_q     <= RST_PAT;
      det_count <= '0;
    end else begin
      l_q       <= l_d;
      hist_q    <= hist_d;
      det_count <= cnt_d;
      if (pat_load)
        pat_q <= pat;
    end
  end

  // Newest bit sits at win[0]; only the last l_q+1 bits are trusted, which bounds k below.
  always_comb begin
    win    = {hist_q, inp};
    l_d    = l_q;
    hist_d = hist_q;
    hit    = 1'b0;
    limit  = 0;
    if (pat_load) begin
      l_d = '0;
    end else if (in_valid) begin
      hist_d = win[PAT_W-2:0];
      if (l_q == L_MATCH && !overlap_en) begin
        l_d = (!mask_q[PAT_W-1] || inp == pat_q[PAT_W-1]) ? LW'(1) : '0;
      end else begin
        limit = (l_q == L_MATCH) ? PAT_W : int'(l_q) + 1;
        l_d   = '0;
        for (int k = 1; k <= PAT_W; k++) begin
          hit = (k <= limit);
          for (int j = 0; j < k; j++) begin
            if (mask_q[PAT_W-k+j] && win[j] != pat_q[PAT_W-k+j])
              hit = 1'b0;
          end
          if (hit)
            l_d = LW'(k);
        end
      end
    end
  end

  assign enter_match = !pat_load && in_valid && (l_d == L_MATCH);

  always_comb begin
    cnt_d = det_count;
    if (cnt_clr)
      cnt_d = enter_match ? CNT_W'(1) : '0;
    else if (enter_match && !cnt_sat)
      cnt_d = det_count + CNT_W'(1);
  end

  assign det     = (l_q == L_MATCH);
  assign cnt_sat = &det_count;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog with PAT_W=3; a second instance with CNT_W=2 covers saturation.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inp, in_valid, pat_load, overlap_en, cnt_clr;
  logic [2:0] pat;
  logic       det, cnt_sat, det2, sat2;
  logic [7:0] det_count;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(.PAT_W(3), .CNT_W(8), .RST_PAT(3'b001)) dut (
    .clk(clk), .reset_n(reset_n), .inp(inp), .in_valid(in_valid), .pat(pat),
    .pat_load(pat_load), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .det(det), .det_count(det_count), .cnt_sat(cnt_sat)
  );

  seq_detect_prog #(.PAT_W(3), .CNT_W(2), .RST_PAT(3'b001)) dut_s (
    .clk(clk), .reset_n(reset_n), .inp(inp), .in_valid(in_valid), .pat(pat),
    .pat_load(pat_load), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .det(det2), .det_count(count2), .cnt_sat(sat2)
  );

  task automatic send_bit(input logic b);
    inp = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      inp = ~inp;
      @(posedge clk); #1;
    end
  endtask

  task automatic load_pat(input logic [2:0] p, input logic b);
    pat = p; pat_load = 1'b1; in_valid = 1'b1; inp = b;
    @(posedge clk); #1;
    pat_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; inp = 1'b0; in_valid = 1'b0; pat = 3'b000;
    pat_load = 1'b0; overlap_en = 1'b1; cnt_clr = 1'b0;
    #12;
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL reset_det got=%b exp=0", det); end
    checks++; if (det_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", det_count); end
    checks++; if (cnt_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", cnt_sat); end
    checks++; if (dut.l_q !== 2'd0) begin errors++; $display("FAIL reset_len got=%0d exp=0", dut.l_q); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b0010;
    logic [3:0] exp  = 4'b0010;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (det !== exp[i]) begin errors++; $display("FAIL basic_det bit%0d got=%b exp=%b", 3-i, det, exp[i]); end
    end
    checks++; if (det_count !== 8'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", det_count); end
  endtask

  task automatic test_load_ignore();
    load_pat(3'b001, 1'b0);
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL load_det got=%b exp=0", det); end
    send_bit(1'b0);
    send_bit(1'b1);
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL load_ignored_inp got=%b exp=0", det); end
    checks++; if (det_count !== 8'd1) begin errors++; $display("FAIL load_count_kept got=%0d exp=1", det_count); end
  endtask

  task automatic test_kmp();
    logic [4:0] bits = 5'b00001;
    logic [4:0] exp  = 5'b00001;
    clear_cnt();
    checks++; if (det_count !== 8'd0) begin errors++; $display("FAIL clr_count got=%0d exp=0", det_count); end
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (det !== exp[i]) begin errors++; $display("FAIL kmp_det bit%0d got=%b exp=%b", 4-i, det, exp[i]); end
    end
    checks++; if (det_count !== 8'd1) begin errors++; $display("FAIL kmp_count got=%0d exp=1", det_count); end
  endtask

  task automatic test_overlap(input logic ov, input logic [4:0] exp, input logic [7:0] exp_cnt);
    logic [4:0] bits = 5'b10101;
    overlap_en = ov;
    load_pat(3'b101, 1'b1);
    clear_cnt();
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (det !== exp[i]) begin errors++; $display("FAIL ovl%0b_det bit%0d got=%b exp=%b", ov, 4-i, det, exp[i]); end
    end
    checks++; if (det_count !== exp_cnt) begin errors++; $display("FAIL ovl%0b_count got=%0d exp=%0d", ov, det_count, exp_cnt); end
    overlap_en = 1'b1;
  endtask

  task automatic test_periodic();
    logic [3:0] exp = 4'b0011;
    load_pat(3'b111, 1'b0);
    clear_cnt();
    for (int i = 3; i >= 0; i--) begin
      send_bit(1'b1);
      checks++;
      if (det !== exp[i]) begin errors++; $display("FAIL periodic_det bit%0d got=%b exp=%b", 3-i, det, exp[i]); end
    end
    checks++; if (det_count !== 8'd2) begin errors++; $display("FAIL periodic_count got=%0d exp=2", det_count); end
  endtask

  task automatic test_hold();
    load_pat(3'b001, 1'b1);
    clear_cnt();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (det !== 1'b1) begin errors++; $display("FAIL hold_det cycle%0d got=%b exp=1", i, det); end
    end
    checks++; if (det_count !== 8'd1) begin errors++; $display("FAIL hold_count got=%0d exp=1", det_count); end
    send_bit(1'b0);
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", det); end
  endtask

  task automatic test_saturate();
    load_pat(3'b111, 1'b0);
    clear_cnt();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    checks++; if (det_count !== 8'd6) begin errors++; $display("FAIL sat_count8 got=%0d exp=6", det_count); end
    checks++; if (count2 !== 2'd3) begin errors++; $display("FAIL sat_count2 got=%0d exp=3", count2); end
    checks++; if (sat2 !== 1'b1) begin errors++; $display("FAIL sat_flag2 got=%b exp=1", sat2); end
    checks++; if (cnt_sat !== 1'b0) begin errors++; $display("FAIL sat_flag8 got=%b exp=0", cnt_sat); end
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL clr_entry_count2 got=%0d exp=1", count2); end
    checks++; if (det_count !== 8'd1) begin errors++; $display("FAIL clr_entry_count8 got=%0d exp=1", det_count); end
    checks++; if (sat2 !== 1'b0) begin errors++; $display("FAIL clr_entry_sat2 got=%b exp=0", sat2); end
    checks++; if (det2 !== 1'b1) begin errors++; $display("FAIL clr_entry_det2 got=%b exp=1", det2); end
    overlap_en = 1'b0;
    send_bit(1'b1);
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL ovl_switch_det got=%b exp=0", det); end
    checks++; if (dut.l_q !== 2'd1) begin errors++; $display("FAIL ovl_switch_len got=%0d exp=1", dut.l_q); end
    overlap_en = 1'b1;
  endtask

  task automatic test_async_reset();
    load_pat(3'b001, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    checks++; if (det !== 1'b1) begin errors++; $display("FAIL pre_reset_det got=%b exp=1", det); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL async_det got=%b exp=0", det); end
    #3 reset_n = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dut.l_q !== 2'd0) begin errors++; $display("FAIL async_len got=%0d exp=0", dut.l_q); end
    checks++; if (det_count !== 8'd0) begin errors++; $display("FAIL async_count got=%0d exp=0", det_count); end
    #3 reset_n = 1'b1;
    send_bit(1'b1);
    checks++; if (det !== 1'b0) begin errors++; $display("FAIL post_reset_det got=%b exp=0", det); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_ignore();
    test_kmp();
    test_overlap(1'b1, 5'b00101, 8'd2);
    test_overlap(1'b0, 5'b00100, 8'd1);
    test_periodic();
    test_hold();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
